// File: rtl/imem_pkg.sv
// Shared sizing constants and loader state encoding for the instruction-memory loader.
package imem_pkg;
  localparam int IMEM_DEPTH  = 256;
  localparam int IMEM_WORD_W = 32;
  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_FLAT_W = IMEM_DEPTH * IMEM_WORD_W;
  localparam int IMEM_CNT_W  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

  // Bursts never exceed one full image.
  function automatic logic [IMEM_CNT_W-1:0] clamp_count(input logic [IMEM_CNT_W-1:0] c);
    return (c > IMEM_CNT_W'(IMEM_DEPTH)) ? IMEM_CNT_W'(IMEM_DEPTH) : c;
  endfunction
endpackage

// File: rtl/imem_loader.sv
// Burst loader that fills a flat instruction-memory image from a valid/ready word stream.
// Optional IMEM_LOADER_CHECKSUM_EN adds a running XOR of the words accepted in the current burst.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int WORD_W = IMEM_WORD_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [IMEM_ADDR_W-1:0]  base_addr,
  input  logic [IMEM_CNT_W-1:0]   word_count,
  input  logic                    in_valid,
  input  logic [WORD_W-1:0]       in_data,
  output logic                    in_ready,
  output logic [DEPTH*WORD_W-1:0] instruction_memory,
  output logic                    busy,
  output logic                    load_done
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]       checksum
`endif
);

  ld_state_e                          r_state, w_state_nxt;
  logic [IMEM_ADDR_W-1:0]             r_ptr;
  logic [IMEM_CNT_W-1:0]              r_rem;
  logic [DEPTH-1:0][WORD_W-1:0]       r_mem;
  logic                               w_take_start;
  logic                               w_xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_take_start = 1'b0;
    w_xfer       = 1'b0;
    in_ready     = 1'b0;
    busy         = 1'b0;
    load_done    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        load_done = (r_state == DONE);
        if (start) begin
          w_take_start = 1'b1;
          w_state_nxt  = (word_count == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // start is deliberately not looked at here: a running burst cannot be restarted.
        if (in_valid) begin
          w_xfer = 1'b1;
          if (r_rem == IMEM_CNT_W'(1)) w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
      r_rem <= '0;
      r_mem <= '0;
    end else if (w_take_start) begin
      r_ptr <= base_addr;
      r_rem <= clamp_count(word_count);
    end else if (w_xfer) begin
      r_mem[r_ptr] <= in_data;
      r_ptr        <= r_ptr + IMEM_ADDR_W'(1);  // natural 8-bit wrap 255 -> 0
      r_rem        <= r_rem - IMEM_CNT_W'(1);
    end
  end

  // Packed element i sits at bits [i*WORD_W +: WORD_W].
  assign instruction_memory = r_mem;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_checksum <= '0;
    else if (w_take_start) r_checksum <= '0;
    else if (w_xfer)       r_checksum <= r_checksum ^ in_data;
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a driver queues expected writes, a monitor checks them.
module tb_imem_loader;
  import imem_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    base_addr = '0;
  logic [8:0]    word_count = '0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready, busy, load_done;
  logic [8191:0] instruction_memory;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  imem_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .instruction_memory(instruction_memory),
    .busy(busy), .load_done(load_done)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;

  int          total = 0;
  int          bad = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] model_mem[256];
  logic [31:0] wbuf[256];
  logic [31:0] exp_ck;
  logic        xfer_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_image(input string nm);
    int first;
    first = -1;
    for (int i = 0; i < 256; i++)
      if (first < 0 && instruction_memory[i*32 +: 32] !== model_mem[i]) first = i;
    total++;
    if (first >= 0) begin
      bad++;
      $display("FAIL %s: word %0d got %h want %h", nm, first,
               instruction_memory[first*32 +: 32], model_mem[first]);
    end
  endtask

  // Handshake seen on an edge; the written word must be visible by the following negedge.
  always @(posedge clk) xfer_prev = reset_n && in_valid && in_ready;

  always @(negedge clk) begin
    if (xfer_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got a transfer want none");
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_word", instruction_memory[int'(mon_e.addr)*32 +: 32], mon_e.data);
      end
    end
  end

  // mode 0: valid every cycle, 1: alternate 1/0, 2: random valid plus stray start pulses
  task automatic run_burst(input logic [7:0] base, input int cnt, input int mode, input string nm);
    int  eff, k, cyc;
    wr_t w;
    eff = (cnt > 256) ? 256 : cnt;
    exp_ck = '0;
    for (int i = 0; i < eff; i++) begin
      w.addr = base + 8'(i);
      w.data = wbuf[i];
      exp_q.push_back(w);
      model_mem[w.addr] = wbuf[i];
      exp_ck ^= wbuf[i];
    end
    base_addr = base; word_count = 9'(cnt); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; base_addr = 8'($urandom); word_count = 9'($urandom);
    @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("checksum_cleared", checksum, 32'h0);
`endif
    if (eff == 0) begin
      chk("zero_load_done", {31'b0, load_done}, 32'd1);
      chk("zero_in_ready", {31'b0, in_ready}, 32'd0);
      chk("zero_busy", {31'b0, busy}, 32'd0);
    end else begin
      chk("load_busy", {31'b0, busy}, 32'd1);
      k = 0; cyc = 0;
      while (k < eff && cyc < 3000) begin
        case (mode)
          0:       in_valid = 1'b1;
          1:       in_valid = (cyc % 2 == 0);
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        in_data = in_valid ? wbuf[k] : $urandom;
        if (mode == 2 && $urandom_range(0, 7) == 0) begin
          start = 1'b1; base_addr = 8'($urandom); word_count = 9'($urandom_range(1, 300));
        end
        @(posedge clk);
        if (in_valid && in_ready) k++;
        cyc++;
        #1 in_valid = 1'b0; start = 1'b0; in_data = $urandom;
      end
      if (k < eff) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: got %0d words want %0d", nm, k, eff);
      end
      @(negedge clk);
      chk("done_load_done", {31'b0, load_done}, 32'd1);
      chk("done_in_ready", {31'b0, in_ready}, 32'd0);
      chk("done_busy", {31'b0, busy}, 32'd0);
    end
    #1 chk("queue_drained", 32'(exp_q.size()), 32'd0);
    check_image(nm);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("checksum", checksum, exp_ck);
`endif
    // Junk offered while DONE must not land anywhere.
    in_valid = 1'b1; in_data = $urandom;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    check_image("idle_junk_ignored");
  endtask

  initial begin
    wr_t w;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    repeat (2) @(negedge clk);
    check_image("reset_image");
    chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_load_done", {31'b0, load_done}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    run_burst(8'd0, 4, 0, "basic4");

    wbuf[0] = 32'hAAAA_0001; wbuf[1] = 32'hBBBB_0002; wbuf[2] = 32'hCCCC_0003;
    run_burst(8'd254, 3, 0, "wrap");

    run_burst(8'd77, 0, 0, "count0");

    for (int i = 0; i < 5; i++) wbuf[i] = $urandom;
    run_burst(8'd100, 5, 1, "toggle5");

    wbuf[0] = 32'hF0F0F0F0; wbuf[1] = 32'h0F0F0F0F;
    run_burst(8'd5, 2, 0, "xor_pair");

    // Abort after two of four words.
    for (int i = 0; i < 2; i++) begin
      w.addr = 8'(10 + i); w.data = 32'hDEAD_0000 + 32'(i);
      exp_q.push_back(w);
    end
    base_addr = 8'd10; word_count = 9'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'hDEAD_0000 + 32'(i);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    @(negedge clk);
    #1 reset_n = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    #1;
    check_image("abort_image");
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_load_done", {31'b0, load_done}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
    chk("abort_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_busy", {31'b0, busy}, 32'd0);
    chk("post_reset_done", {31'b0, load_done}, 32'd0);

    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    run_burst(8'd10, 4, 0, "after_abort");

    for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
    run_burst(8'($urandom), 300, 0, "clamp300");

    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(0, 24);
      for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
      run_burst(8'($urandom), n, 2, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
